// File: rtl/tv_gen_if.sv
// Stimulus and status bundle between the vector generator and the bench
// that consumes it.
interface tv_gen_if;
  logic       in0;
  logic       in1;
  logic [1:0] vec_idx;
  logic       vec_valid;
  logic       pass_wrap;
  logic [7:0] pass_count;
  logic       done;

  modport master (
    output in0, in1, vec_idx, vec_valid, pass_wrap, pass_count, done
  );

  modport slave (
    input in0, in1, vec_idx, vec_valid, pass_wrap, pass_count, done
  );
endinterface

// File: rtl/tv_gen.sv
// Exhaustive 2-input vector generator: steps through all four {in1,in0}
// values in binary or Gray order, holding each for HOLD_CYCLES clocks.
module tv_gen #(
  parameter int HOLD_CYCLES = 1,
  parameter int GRAY        = 0,
  parameter int LOOP        = 1
) (
  input  logic     clk,
  input  logic     rst,
  tv_gen_if.master tv
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] hold_cnt, hold_cnt_nxt;
  logic [1:0] idx, idx_nxt;
  logic [1:0] vec, vec_nxt;
  logic [7:0] passes, passes_nxt;
  logic       valid, valid_nxt;
  logic       wrap, wrap_nxt;
  logic       done, done_nxt;

  function automatic logic [1:0] map_vec(input logic [1:0] i);
    return (GRAY != 0) ? (i ^ (i >> 1)) : i;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    idx_nxt      = idx;
    passes_nxt   = passes;
    valid_nxt    = valid;
    done_nxt     = done;
    wrap_nxt     = 1'b0;

    case (state)
      S_IDLE: begin
        state_nxt    = S_RUN;
        valid_nxt    = 1'b1;
        idx_nxt      = 2'd0;
        hold_cnt_nxt = 8'd0;
      end
      S_RUN: begin
        if (hold_cnt == HOLD_LAST) begin
          hold_cnt_nxt = 8'd0;
          if (idx == 2'd3) begin
            passes_nxt = sat_inc(passes);
            if (LOOP != 0) begin
              idx_nxt  = 2'd0;
              wrap_nxt = 1'b1;
            end else begin
              // Single pass: freeze on the last vector until reset.
              state_nxt = S_DONE;
              valid_nxt = 1'b0;
              done_nxt  = 1'b1;
            end
          end else begin
            idx_nxt = idx + 2'd1;
          end
        end else begin
          hold_cnt_nxt = hold_cnt + 8'd1;
        end
      end
      S_DONE: begin
      end
      default: state_nxt = S_IDLE;
    endcase

    vec_nxt = map_vec(idx_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      hold_cnt <= 8'd0;
      idx      <= 2'd0;
      vec      <= 2'd0;
      passes   <= 8'd0;
      valid    <= 1'b0;
      wrap     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      idx      <= idx_nxt;
      vec      <= vec_nxt;
      passes   <= passes_nxt;
      valid    <= valid_nxt;
      wrap     <= wrap_nxt;
      done     <= done_nxt;
    end
  end

  assign tv.in0        = vec[0];
  assign tv.in1        = vec[1];
  assign tv.vec_idx    = idx;
  assign tv.vec_valid  = valid;
  assign tv.pass_wrap  = wrap;
  assign tv.pass_count = passes;
  assign tv.done       = done;

endmodule

// File: tb/tb_tv_gen.sv
// Bench for tv_gen: four parameterisations run side by side under random
// reset pulses and run lengths, compared each cycle against an edge-count model.
module tb_tv_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   k   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  tv_gen_if b0 ();
  tv_gen_if b1 ();
  tv_gen_if b2 ();
  tv_gen_if b3 ();

  tv_gen #(.HOLD_CYCLES(1), .GRAY(0), .LOOP(1)) u0 (.clk(clk), .rst(rst), .tv(b0));
  tv_gen #(.HOLD_CYCLES(1), .GRAY(1), .LOOP(1)) u1 (.clk(clk), .rst(rst), .tv(b1));
  tv_gen #(.HOLD_CYCLES(3), .GRAY(1), .LOOP(1)) u2 (.clk(clk), .rst(rst), .tv(b2));
  tv_gen #(.HOLD_CYCLES(2), .GRAY(0), .LOOP(0)) u3 (.clk(clk), .rst(rst), .tv(b3));

  // Observed fields packed as {in1,in0, vec_idx, vec_valid, pass_wrap, pass_count, done}
  logic [14:0] o0, o1, o2, o3;
  assign o0 = {b0.in1, b0.in0, b0.vec_idx, b0.vec_valid, b0.pass_wrap, b0.pass_count, b0.done};
  assign o1 = {b1.in1, b1.in0, b1.vec_idx, b1.vec_valid, b1.pass_wrap, b1.pass_count, b1.done};
  assign o2 = {b2.in1, b2.in0, b2.vec_idx, b2.vec_valid, b2.pass_wrap, b2.pass_count, b2.done};
  assign o3 = {b3.in1, b3.in0, b3.vec_idx, b3.vec_valid, b3.pass_wrap, b3.pass_count, b3.done};

  function automatic logic [14:0] model(int kk, int h, bit g, bit l);
    int idx, passes;
    bit wrap, valid, dn;
    logic [1:0] v, iv;
    if (kk == 0) return 15'd0;
    idx    = ((kk - 1) / h) % 4;
    passes = (kk - 1) / (4 * h);
    wrap   = (kk > 1) && (((kk - 1) % (4 * h)) == 0);
    valid  = 1'b1;
    dn     = 1'b0;
    if (!l) begin
      wrap = 1'b0;
      if (kk - 1 >= 4 * h) begin
        idx = 3; valid = 1'b0; dn = 1'b1; passes = 1;
      end else begin
        passes = 0;
      end
    end
    if (passes > 255) passes = 255;
    iv = idx[1:0];
    v  = g ? (iv ^ (iv >> 1)) : iv;
    return {v, iv, valid, wrap, passes[7:0], dn};
  endfunction

  task automatic check_eq(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  task automatic check_all(input string ph);
    check_eq({ph, "/bin_h1"},   o0, model(k, 1, 1'b0, 1'b1));
    check_eq({ph, "/gray_h1"},  o1, model(k, 1, 1'b1, 1'b1));
    check_eq({ph, "/gray_h3"},  o2, model(k, 3, 1'b1, 1'b1));
    check_eq({ph, "/once_h2"},  o3, model(k, 2, 1'b0, 1'b0));
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    if (!rst) k++;
    @(negedge clk);
    check_all(ph);
  endtask

  // Reset asserted mid-cycle; outputs must clear before any further edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 k = 0;
    check_all("async_rst");
    @(negedge clk);
    check_all("in_rst");
    rst = 1'b0;
  endtask

  initial begin
    #1 check_all("reset");
    @(negedge clk);
    check_all("reset_clk");
    rst = 1'b0;
    for (int i = 0; i < 40; i++) step("first");
    for (int s = 0; s < 8; s++) begin
      int n;
      n = $urandom_range(1, 60);
      for (int i = 0; i < n; i++) step("rand");
      async_reset();
    end
    for (int i = 0; i < 1300; i++) step("long");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tv_gen.md
Name: tv_gen

Overview:
- Self-running, exhaustive test-vector generator for 2-input combinational gate benches.
- Drives every combination of {in1,in0} onto a DUT in a fixed order, holding each vector for a programmable number of clock cycles.
- Sits beside the gate under test in a bench: clock/reset in, stimulus bits out, plus status for scoreboards.

Parameters:
- HOLD_CYCLES, 1, clock cycles each vector is held (legal range 1..255).
- GRAY, 0, ordering select: 0 = binary order 00,01,10,11; 1 = Gray order 00,01,11,10 (values are {in1,in0}).
- LOOP, 1, 1 = wrap to first vector after last and run forever; 0 = single pass, then halt.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in0  output  1  stimulus bit 0 (LSB of current vector).
- in1  output  1  stimulus bit 1 (MSB of current vector).
- vec_idx  output  2  sequence position of the vector currently driven (0..3), independent of GRAY.
- vec_valid  output  1  high while in0/in1 carry a live vector.
- pass_wrap  output  1  one-cycle pulse on the edge the index returns 3->0 (LOOP=1 only).
- pass_count  output  8  completed full passes; saturates at 255.
- done  output  1  sticky; LOOP=0 only, high after the final vector's hold expires.

Behaviour:
- Registered outputs only; no combinational path from any input to any output.
- Reset (rst=1, takes effect immediately without a clock): in0=0, in1=0, vec_idx=0, vec_valid=0, pass_wrap=0, pass_count=0, done=0, hold counter=0.
- Edge numbering: edge k is the k-th rising clk edge with rst low (k=1 is the first).
  - Edge 1: vec_valid goes 1, vec_idx=0, vector 00, hold counter=0.
  - Edge k>1: if hold counter = HOLD_CYCLES-1, clear it and advance vec_idx; else increment the counter.
  - Resulting index: vec_idx = floor((k-1)/HOLD_CYCLES) mod 4 while running.
- Vector mapping from vec_idx:
  - GRAY=0: {in1,in0} = vec_idx.
  - GRAY=1: {in1,in0} = vec_idx ^ (vec_idx>>1).
- HOLD_CYCLES=1: vector changes every edge.
- Wrap (LOOP=1):
  - On the edge vec_idx goes 3->0: pass_wrap=1 for exactly that cycle and pass_count increments (holds at 255).
  - Vector 00 is driven again on that same edge.
- Single pass (LOOP=0):
  - On the edge index 3's hold expires: done=1, vec_valid=0, pass_count=1, pass_wrap stays 0.
  - vec_idx stays 3 and in0/in1 hold the last vector (11 binary, 10 Gray).
  - The block then remains frozen until reset.
- Reset mid-sequence: all outputs return to reset values asynchronously; the sequence restarts at edge 1 after release.

Test Plan:
- Defaults, release reset: edges 1..5 give {in1,in0} = 00,01,10,11,00; vec_valid=1 from edge 1; pass_wrap=1 only at edge 5; pass_count=1 after edge 5.
- GRAY=1, HOLD_CYCLES=1: edges 1..4 give 00,01,11,10; vec_idx 0,1,2,3.
- HOLD_CYCLES=3: each vector is stable for exactly 3 edges; vec_idx changes at edges 4, 7, 10; wrap at edge 13.
- LOOP=0, HOLD_CYCLES=2: vectors 00,00,01,01,10,10,11,11 on edges 1..8; edge 9: done=1, vec_valid=0, output stays 11, pass_count=1; no further change over 20 edges.
- Assert rst while vec_idx=2: outputs read 0 before the next edge; after release, edge 1 drives 00 with vec_idx=0 and pass_count=0.
- LOOP=1, run 300 passes: pass_count saturates at 255; pass_wrap still pulses each pass.
